// File: rtl/fir_coef_loader.sv
// Serial loader for a 6-tap coefficient bank: words land in a shadow bank and are
// committed to c0..c5 atomically. Define FIR_COEF_LOADER_COEF_CHECKSUM_EN to require a 7th checksum word.
module fir_coef_loader #(
  parameter int COEF_W  = 14,
  parameter int GAP_MAX = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic signed [COEF_W-1:0] c0,
  output logic signed [COEF_W-1:0] c1,
  output logic signed [COEF_W-1:0] c2,
  output logic signed [COEF_W-1:0] c3,
  output logic signed [COEF_W-1:0] c4,
  output logic signed [COEF_W-1:0] c5,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

`ifdef FIR_COEF_LOADER_COEF_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif
  // Abort fires on the idle cycle that would bring the counter up to GAP_MAX.
  localparam logic [15:0] GAP_LIM = 16'(GAP_MAX - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [2:0]                 r_idx;
  logic [2:0]                 w_idx_nxt;
  logic [15:0]                r_gap;
  logic [15:0]                w_gap_nxt;
  logic signed [COEF_W-1:0]   r_shadow [0:5];
  logic signed [COEF_W-1:0]   r_c      [0:5];
  logic                       r_ready;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
  logic                       w_xfer;
  logic                       w_abort;
  logic                       w_commit;

`ifdef FIR_COEF_LOADER_COEF_CHECKSUM_EN
  function automatic logic [COEF_W-1:0] f_checksum(
    input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b, input logic [COEF_W-1:0] c,
    input logic [COEF_W-1:0] d, input logic [COEF_W-1:0] e, input logic [COEF_W-1:0] f
  );
    return a + b + c + d + e + f;
  endfunction

  logic [COEF_W-1:0] w_sum;
  assign w_sum = f_checksum(r_shadow[0], r_shadow[1], r_shadow[2],
                            r_shadow[3], r_shadow[4], r_shadow[5]);
`endif

  // Next-state, index and gap-counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_xfer      = 1'b0;
    w_abort     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = 3'd0;
          w_gap_nxt   = 16'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (coef_valid) begin
          w_xfer    = 1'b1;
          w_idx_nxt = 3'(r_idx + 3'd1);
          w_gap_nxt = 16'd0;
          if (r_idx == LAST_IDX) begin
`ifdef FIR_COEF_LOADER_COEF_CHECKSUM_EN
            if (coef_in == w_sum) begin
              w_state_nxt = S_COMMIT;
            end else begin
              w_state_nxt = S_IDLE;
              w_abort     = 1'b1;
            end
`else
            w_state_nxt = S_COMMIT;
`endif
          end else begin
            w_state_nxt = S_LOAD;
          end
        end else if (r_gap == GAP_LIM) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
          w_gap_nxt   = 16'd0;
        end else begin
          w_gap_nxt = r_gap + 16'd1;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
        w_commit    = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, shadow bank, active bank and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_gap   <= 16'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < 6; k++) begin
        r_shadow[k] <= '0;
        r_c[k]      <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_ready <= (w_state_nxt == S_LOAD);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_commit;
      r_err   <= w_abort;
      // The checksum word (idx 6) is only compared, never stored.
      for (int k = 0; k < 6; k++) begin
        if (w_xfer && (r_idx == 3'(k))) begin
          r_shadow[k] <= coef_in;
        end
        if (w_commit) begin
          r_c[k] <= r_shadow[k];
        end
      end
    end
  end

  assign coef_ready = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign c0         = r_c[0];
  assign c1         = r_c[1];
  assign c2         = r_c[2];
  assign c3         = r_c[3];
  assign c4         = r_c[4];
  assign c5         = r_c[5];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed self-checking bench for fir_coef_loader (GAP_MAX=4); the checksum
// scenario runs when FIR_COEF_LOADER_COEF_CHECKSUM_EN is defined.
module tb_fir_coef_loader;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start;
  logic signed [13:0] coef_in;
  logic               coef_valid;
  logic               coef_ready;
  logic signed [13:0] c0, c1, c2, c3, c4, c5;
  logic               busy;
  logic               done;
  logic               err;

  int n_cmp = 0;
  int n_bad = 0;
  int cur [6];

  fir_coef_loader #(.COEF_W(14), .GAP_MAX(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .coef_in(coef_in),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bank(input string tag, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int e5);
    chk({tag, "_c0"}, int'(c0), e0);
    chk({tag, "_c1"}, int'(c1), e1);
    chk({tag, "_c2"}, int'(c2), e2);
    chk({tag, "_c3"}, int'(c3), e3);
    chk({tag, "_c4"}, int'(c4), e4);
    chk({tag, "_c5"}, int'(c5), e5);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int v);
    coef_in    = 14'(v);
    coef_valid = 1'b1;
    tick();
    coef_valid = 1'b0;
  endtask

  // Sends the checksum of cur[] when the checksum build is active; otherwise a no-op.
  task automatic send_sum();
`ifdef FIR_COEF_LOADER_COEF_CHECKSUM_EN
    int s;
    s = 0;
    for (int k = 0; k < 6; k++) s += cur[k];
    send_word(s);
`endif
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_cur();
    start();
    for (int k = 0; k < 6; k++) send_word(cur[k]);
    send_sum();
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    coef_in    = '0;
    coef_valid = 1'b0;
    tick();
    chk("rst_ready", int'(coef_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk_bank("rst", 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();

    // Basic load 1..6 with latency check.
    start();
    chk("t1_ready", int'(coef_ready), 1);
    chk("t1_busy", int'(busy), 1);
    for (int k = 0; k < 6; k++) begin
      cur[k] = k + 1;
      send_word(k + 1);
    end
    send_sum();
    chk("t1_ready_commit", int'(coef_ready), 0);
    chk("t1_c0_pre", int'(c0), 0);
    chk("t1_done_pre", int'(done), 0);
    tick();
    chk_bank("t1", 1, 2, 3, 4, 5, 6);
    chk("t1_done", int'(done), 1);
    chk("t1_err", int'(err), 0);
    chk("t1_busy_done", int'(busy), 0);
    tick();
    chk("t1_done_clr", int'(done), 0);

    // Extreme values with coef_valid toggling; garbage on invalid cycles.
    cur[0] = -1; cur[1] = 8191; cur[2] = -8192; cur[3] = 0; cur[4] = 7; cur[5] = -7;
    start();
    for (int i = 0; i < 11; i++) begin
      if (i % 2 == 0) begin
        coef_in    = 14'(cur[i / 2]);
        coef_valid = 1'b1;
      end else begin
        coef_in    = 14'sd100;
        coef_valid = 1'b0;
      end
      tick();
      if (i == 9) chk("t2_ready_mid", int'(coef_ready), 1);
    end
    coef_valid = 1'b0;
    send_sum();
    tick();
    chk_bank("t2", -1, 8191, -8192, 0, 7, -7);
    chk("t2_done", int'(done), 1);

    // Gap abort after three words.
    for (int k = 0; k < 6; k++) cur[k] = 5;
    load_cur();
    tick();
    chk("t3_done", int'(done), 1);
    chk_bank("t3_pre", 5, 5, 5, 5, 5, 5);
    start();
    send_word(9); send_word(9); send_word(9);
    tick(); tick(); tick();
    chk("t3_err_early", int'(err), 0);
    chk("t3_busy_early", int'(busy), 1);
    tick();
    chk("t3_err", int'(err), 1);
    chk("t3_done_abort", int'(done), 0);
    chk("t3_busy", int'(busy), 0);
    chk("t3_ready", int'(coef_ready), 0);
    chk_bank("t3", 5, 5, 5, 5, 5, 5);
    tick();
    chk("t3_err_clr", int'(err), 0);

    // Reset mid-load.
    start();
    send_word(1); send_word(2); send_word(3);
    reset = 1'b0;
    tick();
    chk_bank("t4", 0, 0, 0, 0, 0, 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_ready", int'(coef_ready), 0);
    chk("t4_done", int'(done), 0);
    chk("t4_err", int'(err), 0);
    reset = 1'b1;
    tick();
    chk("t4_done2", int'(done), 0);
    chk("t4_err2", int'(err), 0);

    // load_start ignored during LOAD, accepted in the done cycle.
    for (int k = 0; k < 6; k++) cur[k] = 10 + k;
    start();
    send_word(10);
    load_start = 1'b1;
    send_word(11);
    load_start = 1'b0;
    send_word(12); send_word(13); send_word(14); send_word(15);
    send_sum();
    tick();
    chk("t5_done", int'(done), 1);
    chk_bank("t5", 10, 11, 12, 13, 14, 15);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t5_ready", int'(coef_ready), 1);
    chk("t5_busy", int'(busy), 1);
    chk("t5_done_clr", int'(done), 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

`ifdef FIR_COEF_LOADER_COEF_CHECKSUM_EN
    // Checksum match commits, mismatch aborts.
    start();
    for (int k = 1; k <= 6; k++) send_word(k);
    send_word(21);
    tick();
    chk("t6_done", int'(done), 1);
    chk_bank("t6", 1, 2, 3, 4, 5, 6);
    start();
    for (int k = 2; k <= 7; k++) send_word(k);
    send_word(26);
    chk("t6_err", int'(err), 1);
    chk("t6_done_bad", int'(done), 0);
    chk("t6_busy", int'(busy), 0);
    chk_bank("t6_bad", 1, 2, 3, 4, 5, 6);
    tick();
    chk("t6_err_clr", int'(err), 0);
    chk("t6_done_clr", int'(done), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter COEF_W, default 14: coefficient word width in bits; all coefficient ports and registers are COEF_W wide, two's complement.
REQ-002 Parameter GAP_MAX, default 255: number of consecutive idle LOAD cycles before the load is aborted; range 1..65535.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 load_start  input  1  one-cycle request to begin a new coefficient load.
REQ-006 coef_in  input  COEF_W  serial coefficient word, signed.
REQ-007 coef_valid  input  1  coef_in holds a valid word.
REQ-008 coef_ready  output  1  loader accepts a word this cycle.
REQ-009 c0..c5  output  COEF_W each  active coefficient bank; these are the tap inputs of the downstream transposed FIR.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse: a new bank has been committed.
REQ-012 err  output  1  one-cycle pulse: a load was aborted.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD and COMMIT, all registered.
REQ-014 IDLE: coef_ready=0; load_start=1 SHALL move to LOAD, clear the word index idx to 0 and clear the gap counter.
REQ-015 LOAD: coef_ready=1; a transfer occurs on an edge where coef_valid=1 and coef_ready=1.
REQ-016 A transfer SHALL write coef_in into shadow[idx], increment idx and clear the gap counter; word k goes to shadow k, so the first word goes to c0 and the sixth to c5.
REQ-017 The transfer of the final word (idx=5; idx=6 with COEF_CHECKSUM_EN) SHALL move the FSM to COMMIT, with coef_ready=0 from the next cycle.
REQ-018 Each LOAD cycle without a transfer SHALL increment the gap counter; when the counter reaches GAP_MAX, the FSM SHALL return to IDLE, pulse err for one cycle, and leave c0..c5 unchanged.
REQ-019 load_start SHALL be ignored in LOAD and COMMIT; a load in progress is never restarted.
REQ-020 COMMIT lasts exactly one cycle: on its closing edge, c0..c5 SHALL load shadow0..shadow5 simultaneously, done SHALL assert for the following cycle, and the FSM SHALL return to IDLE.
REQ-021 c0..c5 SHALL change only on a commit edge or on reset; a partial or aborted load never alters them.
REQ-022 Latency from the final transfer edge to the new c0..c5 being visible SHALL be 2 edges; done is high in the first cycle the new values are visible.
REQ-023 load_start asserted in the same cycle that done is high SHALL be accepted normally, because the FSM is already in IDLE.
REQ-024 done and err SHALL never be high in the same cycle.

Reset
REQ-025 When reset=0 at a rising edge, the FSM SHALL enter IDLE, and idx, the gap counter, shadow0..5, c0..c5, done and err SHALL all become 0.
REQ-026 A reset during LOAD or COMMIT SHALL discard the load; no done or err pulse is produced.
REQ-027 coef_ready and busy SHALL be 0 in the first cycle after reset.

Configuration
REQ-028 Macro FIR_COEF_LOADER_COEF_CHECKSUM_EN.
REQ-029 When the macro is defined, LOAD SHALL accept a seventh word (idx=6) as a checksum: the low COEF_W bits of the two's-complement sum of the six coefficients.
REQ-030 With the macro defined, a matching checksum SHALL proceed to COMMIT; a mismatch SHALL return the FSM to IDLE, pulse err, and leave c0..c5 unchanged.
REQ-031 When the macro is undefined, exactly six words form a load, no checksum logic exists, and err is driven only by the gap abort.

Verification
REQ-032 Reset, then load_start, then words 1,2,3,4,5,6 on consecutive cycles -> c0..c5=1..6 two edges after the sixth transfer, done high for one cycle, busy low after done.
REQ-033 Load words -1,0x1FFF,-8192,0,7,-7 with coef_valid toggled 1,0,1,0,... -> same bank committed, each word accepted only on coef_valid=1 cycles.
REQ-034 GAP_MAX=4: after a committed bank of all 5s, three words then coef_valid=0 for 4 cycles -> err pulse, FSM in IDLE, c0..c5 still 5.
REQ-035 reset=0 asserted mid-load after 3 words -> all outputs 0 next cycle, no done and no err.
REQ-036 Macro defined: words 1..6 with checksum 21 -> commit with done; repeat with checksum 20 -> err pulse, c0..c5 unchanged.
REQ-037 load_start pulsed during LOAD and in the done cycle -> the first is ignored; the second starts a new load with coef_ready=1 on the next cycle.
